// File: rtl/tdc_phase_gen.sv
// Multi-phase clock-enable generator for the TDC front end.
// N_PHASES square-wave enables share a programmable period P and are staggered
// by a programmable phase step. Outputs stay gated until the synchronised PLL
// lock has been stable for SETTLE_CYC cycles and the per-phase counters have
// been preset. All outputs are registered.
module tdc_phase_gen #(
  parameter int N_PHASES   = 10,
  parameter int DIV_W      = 8,
  parameter int LOCK_SYNC  = 2,
  parameter int SETTLE_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                enable,
  input  logic [DIV_W-1:0]    div,
  input  logic [DIV_W-1:0]    step,
  output logic [N_PHASES-1:0] clocks,
  output logic [N_PHASES-1:0] inv_clocks,
  output logic [N_PHASES-1:0] phase_stb,
  output logic                ready,
  output logic                cfg_err
);

  // One extra bit so that P = 2^DIV_W and c + P stay representable.
  localparam int CW = DIV_W + 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int LW = $clog2(N_PHASES);

  typedef enum logic [2:0] {IDLE, WAIT, SETTLE, LOAD, RUN} state_t;

  state_t                  state;
  logic [LOCK_SYNC-1:0]    sync_q;
  logic                    lk;
  logic [SW-1:0]           settle_cnt;
  logic [LW-1:0]           ld_idx;
  logic                    run_nxt;
  logic [CW-1:0]           p_r;
  logic [CW-1:0]           s_r;
  logic [CW-1:0]           hi_r;
  logic [CW-1:0]           cnt     [N_PHASES];
  logic [CW-1:0]           cnt_nxt [N_PHASES];

  // Effective period: div of 0 is promoted to 1, so P is at least 2.
  function automatic logic [CW-1:0] eff_period(input logic [DIV_W-1:0] d);
    return (d == '0) ? CW'(2) : CW'(d) + CW'(1);
  endfunction

  // Effective step, clamped to P-1 (which equals the promoted div).
  function automatic logic [CW-1:0] eff_step(input logic [DIV_W-1:0] d,
                                             input logic [DIV_W-1:0] st);
    logic [CW-1:0] pm1;
    pm1 = (d == '0) ? CW'(1) : CW'(d);
    return (CW'(st) > pm1) ? pm1 : CW'(st);
  endfunction

  // True when either the period or the step had to be clamped.
  function automatic logic clamp_err(input logic [DIV_W-1:0] d,
                                     input logic [DIV_W-1:0] st);
    logic [CW-1:0] pm1;
    pm1 = (d == '0) ? CW'(1) : CW'(d);
    return (d == '0) || (CW'(st) > pm1);
  endfunction

  // (c - s) mod p by compare-subtract; c < p and s < p are guaranteed.
  function automatic logic [CW-1:0] back_off(input logic [CW-1:0] c,
                                             input logic [CW-1:0] s,
                                             input logic [CW-1:0] p);
    return (c >= s) ? (c - s) : (c + p - s);
  endfunction

  // Counter advance wrapping P-1 -> 0.
  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] c,
                                             input logic [CW-1:0] p);
    return (c == p - CW'(1)) ? '0 : c + CW'(1);
  endfunction

  assign lk         = sync_q[LOCK_SYNC-1];
  assign inv_clocks = ~clocks;

  // Next cycle is a RUN cycle: stays in RUN, or finishes the last LOAD cycle.
  assign run_nxt = enable && lk &&
                   ((state == RUN) ||
                    ((state == LOAD) && (ld_idx == LW'(N_PHASES - 1))));

  // Lock synchroniser; pll_locked is asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[LOCK_SYNC-2:0], pll_locked};
  end

  // Sequencing FSM: enable drop wins over lock loss, lock loss restarts at WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WAIT;
      settle_cnt <= '0;
      ld_idx     <= '0;
      ready      <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      ready <= run_nxt;
      if ((state == LOAD) && (ld_idx == '0)) cfg_err <= clamp_err(div, step);
      if (!enable) begin
        state <= IDLE;
      end else if ((state != IDLE) && !lk) begin
        state <= WAIT;
      end else begin
        case (state)
          IDLE: state <= WAIT;
          WAIT: begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
          SETTLE: begin
            if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
              state  <= LOAD;
              ld_idx <= '0;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
          LOAD: begin
            if (ld_idx == LW'(N_PHASES - 1)) state <= RUN;
            else                             ld_idx <= ld_idx + LW'(1);
          end
          RUN:     state <= RUN;
          default: state <= WAIT;
        endcase
      end
    end
  end

  // Configuration snapshot taken on the first LOAD cycle.
  always_ff @(posedge clk) begin
    if ((state == LOAD) && (ld_idx == '0)) begin
      p_r  <= eff_period(div);
      s_r  <= eff_step(div, step);
      hi_r <= (eff_period(div) + CW'(1)) >> 1;
    end
  end

  // Counter next values: wrap in RUN, preset one phase per LOAD cycle.
  // Preset value (P - offs[k]) mod P follows from the previous phase minus s.
  always_comb begin
    for (int k = 0; k < N_PHASES; k++)
      cnt_nxt[k] = (state == RUN) ? wrap_inc(cnt[k], p_r) : cnt[k];
    if (state == LOAD) begin
      if (ld_idx == '0) cnt_nxt[0] = '0;
      for (int k = 1; k < N_PHASES; k++)
        if (ld_idx == LW'(k)) cnt_nxt[k] = back_off(cnt[k-1], s_r, p_r);
    end
  end

  // Per-phase counter registers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_PHASES; k++) cnt[k] <= cnt_nxt[k];
  end

  // Registered phase outputs, decoded from the counter value of the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clocks    <= '0;
      phase_stb <= '0;
    end else begin
      for (int k = 0; k < N_PHASES; k++) begin
        clocks[k]    <= run_nxt && (cnt_nxt[k] < hi_r);
        phase_stb[k] <= run_nxt && (cnt_nxt[k] == '0);
      end
    end
  end

endmodule

// File: tb/tb_tdc_phase_gen.sv
// Bench for tdc_phase_gen: directed and randomized stimulus compared every
// cycle against a progress-count reference model with arithmetic phase decode.
module tb_tdc_phase_gen;

  localparam int N    = 10;
  localparam int DW   = 8;
  localparam int LS   = 2;
  localparam int SC   = 16;
  localparam int RUNP = 1 + SC + N;

  logic          clk;
  logic          rst;
  logic          pll_locked;
  logic          enable;
  logic [DW-1:0] div;
  logic [DW-1:0] step;
  logic [N-1:0]  clocks;
  logic [N-1:0]  inv_clocks;
  logic [N-1:0]  phase_stb;
  logic          ready;
  logic          cfg_err;

  tdc_phase_gen #(
    .N_PHASES(N), .DIV_W(DW), .LOCK_SYNC(LS), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .enable(enable),
    .div(div), .step(step), .clocks(clocks), .inv_clocks(inv_clocks),
    .phase_stb(phase_stb), .ready(ready), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: progress = consecutive advancing cycles since WAIT.
  // 0 = waiting, 1..SC settling, SC+1..SC+N loading, RUNP = running.
  bit m_idle;
  int m_prog;
  int m_t;
  int m_p;
  int m_s;
  bit m_err;
  bit hist [LS];

  task automatic model_reset();
    m_idle = 1'b0;
    m_prog = 0;
    m_t    = 0;
    m_p    = 2;
    m_s    = 0;
    m_err  = 1'b0;
    for (int i = 0; i < LS; i++) hist[i] = 1'b0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] ec;
    logic [N-1:0] es;
    logic [N-1:0] einv;
    bit r;
    int hi;
    int off;
    int ph;
    r  = !m_idle && (m_prog == RUNP);
    hi = (m_p + 1) / 2;
    for (int k = 0; k < N; k++) begin
      off = (k * m_s) % m_p;
      ph  = (m_t - off) % m_p;
      if (ph < 0) ph += m_p;
      ec[k] = r && (ph < hi);
      es[k] = r && (ph == 0);
    end
    einv = ~ec;
    chk("ready", ready, r);
    chk("clocks", clocks, ec);
    chk("inv_clocks", inv_clocks, einv);
    chk("phase_stb", phase_stb, es);
    chk("cfg_err", cfg_err, m_err);
  endtask

  // One clock edge: advance the model with the inputs held across the edge.
  task automatic cyc();
    bit lk_now;
    bit was_run;
    int d;
    @(posedge clk);
    lk_now = hist[LS-1];
    for (int i = LS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pll_locked;
    was_run = !m_idle && (m_prog == RUNP);
    if (!m_idle && (m_prog == SC + 1)) begin
      d     = (div == 0) ? 1 : int'(div);
      m_p   = d + 1;
      m_s   = (int'(step) > d) ? d : int'(step);
      m_err = (div == 0) || (int'(step) > d);
    end
    if (!enable) begin
      m_idle = 1'b1;
      m_prog = 0;
    end else if (m_idle) begin
      m_idle = 1'b0;
      m_prog = 0;
    end else if (!lk_now) begin
      m_prog = 0;
    end else if (m_prog < RUNP) begin
      m_prog++;
    end
    if (!m_idle && (m_prog == RUNP)) m_t = was_run ? m_t + 1 : 0;
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!ready && n < 600) begin
      cyc();
      n++;
    end
    chk(tag, ready, 1'b1);
  endtask

  task automatic restart(input int d, input int st);
    enable = 1'b0;
    cyc();
    div    = DW'(d);
    step   = DW'(st);
    enable = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, ready, 1'b0);
    chk({tag, "_clocks"}, clocks, '0);
    chk({tag, "_inv"}, inv_clocks, {N{1'b1}});
    chk({tag, "_stb"}, phase_stb, '0);
    chk({tag, "_err"}, cfg_err, 1'b0);
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    pll_locked = 1'b1;
    enable     = 1'b1;
    div        = 8'd9;
    step       = 8'd1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;

    // Lock held from release: sync + settle + load + one transition.
    wait_ready("case1_ready", n);
    chk("case1_latency", n, LS + SC + N + 1);
    run(35);

    // Step 3 over period 10.
    restart(9, 3);
    wait_ready("case2_ready", n);
    run(30);

    // Odd period, unequal duty.
    restart(4, 2);
    wait_ready("case3_ready", n);
    run(25);

    // Step clamp, then period clamp.
    restart(3, 7);
    wait_ready("case4a_ready", n);
    run(15);
    restart(0, 5);
    wait_ready("case4b_ready", n);
    run(15);

    // Clean config clears the sticky error at the next LOAD.
    restart(7, 2);
    wait_ready("clear_ready", n);
    run(20);

    // Lock loss in RUN; div change during RUN only takes effect after restart.
    div = 8'd5;
    run(20);
    pll_locked = 1'b0;
    run(5);
    pll_locked = 1'b1;
    wait_ready("case5_ready", n);
    run(20);

    // Large period.
    restart(200, 77);
    wait_ready("big_ready", n);
    run(420);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("held_rst");
    div  = 8'd9;
    step = 8'd1;
    rst  = 1'b1;
    wait_ready("post_rst_ready", n);
    run(10);

    // Randomized sessions with glitches and enable drops.
    for (int it = 0; it < 12; it++) begin
      restart($urandom_range(0, 20), $urandom_range(0, 24));
      wait_ready("rand_ready", n);
      run($urandom_range(20, 60));
      div  = DW'($urandom);
      step = DW'($urandom);
      run(5);
      case ($urandom_range(0, 2))
        0: begin
          pll_locked = 1'b0;
          run($urandom_range(1, 4));
          pll_locked = 1'b1;
        end
        1: begin
          enable = 1'b0;
          run(1);
          enable = 1'b1;
        end
        default: ;
      endcase
      run($urandom_range(10, 40));
    end

    // Free-running chaos on every input.
    for (int c = 0; c < 1500; c++) begin
      pll_locked = ($urandom_range(0, 59) != 0);
      enable     = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 7) == 0) begin
        div  = DW'($urandom_range(0, 12));
        step = DW'($urandom_range(0, 15));
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_phase_gen.md
Name: tdc_phase_gen

Overview:
Parametrised multi-phase clock-enable generator for the TDC front end. It is the successor to the fixed 10-output PLL clock block.
- Produces N_PHASES phase-staggered square-wave enables, their complements and one-cycle phase strobes from a single fabric clock.
- Period and phase step are programmable.
- Outputs are gated until the PLL reports lock and a settle interval has elapsed.

Parameters:
N_PHASES, 10, number of output phases (>=2)
DIV_W, 8, width of div and step fields
LOCK_SYNC, 2, synchroniser depth for pll_locked (>=2)
SETTLE_CYC, 16, cycles of continuous synchronised lock required before offset load (>=1)

Ports:
clk  in  1  fabric clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
pll_locked  in  1  PLL lock, asynchronous to clk
enable  in  1  level; 1 = generate, 0 = idle
div  in  DIV_W  period minus one; P = div+1
step  in  DIV_W  phase offset increment between adjacent phases, in clk cycles
clocks  out  N_PHASES  phase square waves
inv_clocks  out  N_PHASES  bitwise complement of clocks, always
phase_stb  out  N_PHASES  one-cycle strobe at each phase's rising point
ready  out  1  high only in RUN
cfg_err  out  1  sticky until next LOAD; set when div<1 or step>div was seen at LOAD

Behaviour:
- Reset (rst=0, async): state=WAIT, clocks=0, inv_clocks=all 1, phase_stb=0, ready=0, cfg_err=0, synchroniser flops=0.
- pll_locked passes through LOCK_SYNC flops to give lk. All lock decisions use lk.
- FSM states:
  - IDLE: outputs gated. Go to WAIT when enable=1.
  - WAIT: go to SETTLE when lk=1.
  - SETTLE: count SETTLE_CYC consecutive cycles with lk=1, then go to LOAD.
  - LOAD: exactly N_PHASES cycles, then go to RUN.
  - RUN: normal generation.
- In any state, enable=0 forces IDLE next cycle. Otherwise, in any non-IDLE state, lk=0 forces WAIT next cycle. enable has priority over lk.
- Gating: in every state except RUN, clocks=0, inv_clocks=all 1, phase_stb=0, ready=0. Entering WAIT or IDLE from RUN drops outputs in the first cycle of the new state.
- LOAD captures div and step on its first cycle; later changes to either input are ignored until the next LOAD.
  - Effective P = max(div,1)+1.
  - Effective step s = min(step, P-1).
  - cfg_err is set if either clamp applied.
  - Offsets are computed sequentially, one per cycle: offs[0]=0; offs[k]=(offs[k-1]+s) mod P, with the modulo done as a compare-subtract. No dividers.
- RUN: let t = cycles since RUN entry (t=0 is the first RUN cycle), and HI = (P+1)>>1.
  - ready=1.
  - clocks[k] = (((t - offs[k]) mod P) < HI).
  - phase_stb[k] = (((t - offs[k]) mod P) == 0).
  - Implementation: one wrapping counter per phase, preset in LOAD to (P - offs[k]) mod P, wrapping P-1 -> 0.
- Duty cycle: P even gives exactly 50%; P odd gives HI high cycles and P-HI low cycles.
- Coincident offsets (e.g. s=0) are legal; the affected phases are identical.
- Reset mid-operation: immediate return to reset values regardless of state.
- A lock glitch shorter than the synchroniser path is not filtered. Any synchronised low restarts the full sequence from WAIT.

Test Plan:
- Case 1: N=10, div=9, step=1, lock held, enable=1 from reset release.
  - ready rises 2+16+10 cycles after lock (sync + settle + load), +1 cycle for each FSM transition as implemented; the bench checks the exact entry cycle against the FSM trace.
  - Then clocks[k] goes high at t=k mod 10 for 5 cycles; phase_stb[3] at t=3,13,23.
- Case 2: div=9, step=3.
  - Offsets = 0,3,6,9,2,5,8,1,4,7.
  - phase_stb[4] at t=2,12; clocks[3] high t=9..13.
- Case 3: div=4 (P=5), step=2.
  - HI=3; clocks[1] high t=2..4, low t=5..6; inv_clocks always == ~clocks.
- Case 4: div=3, step=7.
  - s clamped to 3, cfg_err=1, offsets 0,3,2,1,0,...
  - div=0 -> P=2, cfg_err=1.
- Case 5: RUN then pll_locked=0 for 5 cycles.
  - Outputs gated within LOCK_SYNC+1 cycles; no phase_stb while gated.
  - After lock returns, full SETTLE+LOAD precedes ready.
  - Changing div during RUN has no effect until the next restart.
- Case 6: RUN then rst=0 asynchronously mid-cycle.
  - All outputs return to reset values without waiting for a clk edge.
  - enable=0 in RUN -> IDLE next cycle, clocks=0.
